mips_mem_arbiter_vn: RTL and testbench

MIPS_MEM_ARBITER_VN -- requirements
Module: mips_mem_arbiter_vn

---
 rtl/mips_mem_arbiter_vn.sv | 95 +++++++++
 tb/tb_mips_mem_arbiter_vn.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/mips_mem_arbiter_vn.sv
// mips_mem_arbiter_vn: arbitrates CH requesters onto one shared von Neumann memory port
module mips_mem_arbiter_vn #(
   parameter int N    = 32,
   parameter int A    = 32,
   parameter int CH   = 3,
   parameter int WAIT = 1,
   parameter int RR   = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  ena,
   input  logic [CH-1:0]         req_valid,
   input  logic [CH-1:0]         req_wr,
   input  logic [CH*A-1:0]       req_addr,
   input  logic [CH*N-1:0]       req_wr_data,
   output logic [CH-1:0]         req_ready,
   output logic [CH-1:0]         rsp_valid,
   output logic [N-1:0]          rsp_data,
   output logic                  busy,
   output logic [$clog2(CH)-1:0] grant_id,
   output logic [A-1:0]          mem_addr,
   output logic [N-1:0]          mem_wr_data,
   output logic                  mem_wr_ena,
   input  logic [N-1:0]          mem_rd_data
);
   localparam int GW = $clog2(CH);
   typedef enum logic [1:0] {IDLE, ISSUE, RWAIT, DONE} state_t;
   state_t state;
   logic [3:0] cnt;
   logic [GW-1:0] last_grant, start, sel;
   logic [GW:0] idx;
   logic take;
   assign start = (RR != 0 && last_grant != GW'(CH - 1)) ? last_grant + 1'b1 : '0;
   assign take = rst && ena && state == IDLE && |req_valid;
   assign req_ready = take ? CH'(1) << sel : '0;
   // scan downward so the valid channel nearest the search start wins
   always_comb begin
      sel = '0;
      idx = '0;
      for (int k = CH - 1; k >= 0; k--) begin
         idx = {1'b0, start} + (GW + 1)'(k);
         idx = idx >= (GW + 1)'(CH) ? idx - (GW + 1)'(CH) : idx;
         sel = req_valid[idx[GW-1:0]] ? idx[GW-1:0] : sel;
      end
   end
   // access sequencer; memory-side outputs are registered on entry to each state
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         cnt         <= '0;
         last_grant  <= '0;
         rsp_data    <= '0;
         rsp_valid   <= '0;
         busy        <= 1'b0;
         grant_id    <= '0;
         mem_addr    <= '0;
         mem_wr_data <= '0;
         mem_wr_ena  <= 1'b0;
      end else begin
         rsp_valid <= '0;
         case (state)
            IDLE: if (take) begin
               state       <= ISSUE;
               busy        <= 1'b1;
               grant_id    <= sel;
               last_grant  <= sel;
               mem_addr    <= req_addr[sel*A +: A];
               mem_wr_ena  <= req_wr[sel];
               mem_wr_data <= req_wr[sel] ? req_wr_data[sel*N +: N] : '0;
            end
            ISSUE: begin
               mem_wr_ena  <= 1'b0;
               mem_wr_data <= '0;
               cnt         <= 4'(WAIT - 1);
               state       <= mem_wr_ena ? DONE : RWAIT;
               mem_addr    <= mem_wr_ena ? '0 : mem_addr;
               rsp_valid   <= mem_wr_ena ? CH'(1) << grant_id : '0;
            end
            RWAIT: if (cnt == 4'd0) begin
               rsp_data  <= mem_rd_data;
               mem_addr  <= '0;
               rsp_valid <= CH'(1) << grant_id;
               state     <= DONE;
            end else begin
               cnt <= cnt - 4'd1;
            end
            DONE: begin
               state    <= IDLE;
               busy     <= 1'b0;
               grant_id <= '0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_mips_mem_arbiter_vn.sv
// tb_mips_mem_arbiter_vn: directed checks on round-robin, WAIT=4 and fixed-priority instances
module tb_mips_mem_arbiter_vn;
   logic clk = 1'b0;
   logic rst = 1'b0;
   logic ena = 1'b0;
   logic [2:0] req_valid = '0;
   logic [2:0] req_wr = '0;
   logic [95:0] req_addr = '0;
   logic [95:0] req_wr_data = '0;
   logic [31:0] mem_rd_data = 32'hDEADBEEF;
   logic [2:0] req_ready_a, rsp_valid_a, req_ready_w, rsp_valid_w, req_ready_f, rsp_valid_f;
   logic [31:0] rsp_data_a, rsp_data_w, rsp_data_f;
   logic busy_a, busy_w, busy_f;
   logic [1:0] grant_id_a, grant_id_w, grant_id_f;
   logic [31:0] mem_addr_a, mem_addr_w, mem_addr_f;
   logic [31:0] mem_wr_data_a, mem_wr_data_w, mem_wr_data_f;
   logic mem_wr_ena_a, mem_wr_ena_w, mem_wr_ena_f;
   int errors = 0;
   int checks = 0;
   int grants [6];
   int n;

   always #5 clk = ~clk;

   mips_mem_arbiter_vn #(.N(32), .A(32), .CH(3), .WAIT(1), .RR(1)) dut_a (
      .clk(clk), .rst(rst), .ena(ena), .req_valid(req_valid), .req_wr(req_wr),
      .req_addr(req_addr), .req_wr_data(req_wr_data), .req_ready(req_ready_a),
      .rsp_valid(rsp_valid_a), .rsp_data(rsp_data_a), .busy(busy_a), .grant_id(grant_id_a),
      .mem_addr(mem_addr_a), .mem_wr_data(mem_wr_data_a), .mem_wr_ena(mem_wr_ena_a),
      .mem_rd_data(mem_rd_data));
   mips_mem_arbiter_vn #(.N(32), .A(32), .CH(3), .WAIT(4), .RR(1)) dut_w (
      .clk(clk), .rst(rst), .ena(ena), .req_valid(req_valid), .req_wr(req_wr),
      .req_addr(req_addr), .req_wr_data(req_wr_data), .req_ready(req_ready_w),
      .rsp_valid(rsp_valid_w), .rsp_data(rsp_data_w), .busy(busy_w), .grant_id(grant_id_w),
      .mem_addr(mem_addr_w), .mem_wr_data(mem_wr_data_w), .mem_wr_ena(mem_wr_ena_w),
      .mem_rd_data(mem_rd_data));
   mips_mem_arbiter_vn #(.N(32), .A(32), .CH(3), .WAIT(1), .RR(0)) dut_f (
      .clk(clk), .rst(rst), .ena(ena), .req_valid(req_valid), .req_wr(req_wr),
      .req_addr(req_addr), .req_wr_data(req_wr_data), .req_ready(req_ready_f),
      .rsp_valid(rsp_valid_f), .rsp_data(rsp_data_f), .busy(busy_f), .grant_id(grant_id_f),
      .mem_addr(mem_addr_f), .mem_wr_data(mem_wr_data_f), .mem_wr_ena(mem_wr_ena_f),
      .mem_rd_data(mem_rd_data));

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      req_valid = '0;
      rst = 1'b0;
      tick();
      tick();
      rst = 1'b1;
   endtask

   function automatic int idx_of(input logic [2:0] v);
      return v[0] ? 0 : v[1] ? 1 : v[2] ? 2 : -1;
   endfunction

   initial begin
      req_valid = 3'b111;
      ena = 1'b1;
      #2;
      chk("rst_ready", req_ready_a, 0);
      chk("rst_busy", busy_a, 0);
      chk("rst_addr", mem_addr_a, 0);
      chk("rst_rsp", rsp_data_a, 0);
      do_reset();
      // single read: ch1 @0x40 returns DEADBEEF
      req_valid = 3'b010;
      req_wr = 3'b000;
      req_addr[32 +: 32] = 32'h40;
      #1 chk("rd_ready_t", req_ready_a, 3'b010);
      tick();
      req_valid = '0;
      chk("rd_addr_t1", mem_addr_a, 32'h40);
      chk("rd_grant_t1", grant_id_a, 1);
      chk("rd_busy_t1", busy_a, 1);
      chk("rd_wena_t1", mem_wr_ena_a, 0);
      tick();
      chk("rd_addr_t2", mem_addr_a, 32'h40);
      chk("rd_rsp_t2", rsp_valid_a, 0);
      tick();
      chk("rd_rsp_t3", rsp_valid_a, 3'b010);
      chk("rd_data_t3", rsp_data_a, 32'hDEADBEEF);
      chk("rd_addr_t3", mem_addr_a, 0);
      tick();
      chk("rd_rsp_t4", rsp_valid_a, 0);
      chk("rd_busy_t4", busy_a, 0);
      do_reset();
      rst = 1'b1;
      // single write: ch2 writes 0x12345678 to 0x100; rsp_data untouched since reset
      req_valid = 3'b100;
      req_wr = 3'b100;
      req_addr[64 +: 32] = 32'h100;
      req_wr_data[64 +: 32] = 32'h12345678;
      #1 chk("wr_ready_t", req_ready_a, 3'b100);
      tick();
      req_valid = '0;
      req_wr = '0;
      chk("wr_wena_t1", mem_wr_ena_a, 1);
      chk("wr_addr_t1", mem_addr_a, 32'h100);
      chk("wr_data_t1", mem_wr_data_a, 32'h12345678);
      tick();
      chk("wr_rsp_t2", rsp_valid_a, 3'b100);
      chk("wr_wena_t2", mem_wr_ena_a, 0);
      chk("wr_addr_t2", mem_addr_a, 0);
      chk("wr_rspdata", rsp_data_a, 0);
      tick();
      chk("wr_rsp_t3", rsp_valid_a, 0);
      // round-robin fairness from reset; fixed priority always picks ch0
      do_reset();
      req_valid = 3'b111;
      n = 0;
      for (int c = 0; c < 60 && n < 6; c++) begin
         #1;
         if (req_ready_a != 0) begin
            grants[n] = idx_of(req_ready_a);
            chk("fp_grant", req_ready_f, 3'b001);
            n++;
         end
         tick();
      end
      chk("rr_count", n, 6);
      for (int i = 0; i < 6; i++) chk($sformatf("rr_grant%0d", i), grants[i], (i + 1) % 3);
      // WAIT=4 read on the second instance
      do_reset();
      mem_rd_data = 32'h11111111;
      req_valid = 3'b001;
      req_addr[0 +: 32] = 32'h200;
      #1 chk("w4_ready_t", req_ready_w, 3'b001);
      for (int k = 1; k <= 5; k++) begin
         tick();
         req_valid = '0;
         if (k == 5) mem_rd_data = 32'hCAFEF00D;
         chk($sformatf("w4_addr_t%0d", k), mem_addr_w, 32'h200);
         chk($sformatf("w4_rsp_t%0d", k), rsp_valid_w, 0);
      end
      tick();
      mem_rd_data = '0;
      chk("w4_rsp_t6", rsp_valid_w, 3'b001);
      chk("w4_data_t6", rsp_data_w, 32'hCAFEF00D);
      chk("w4_addr_t6", mem_addr_w, 0);
      tick();
      chk("w4_hold", rsp_data_w, 32'hCAFEF00D);
      // ena dropped while a read is in flight
      do_reset();
      mem_rd_data = 32'h0BADF00D;
      req_valid = 3'b001;
      req_addr[0 +: 32] = 32'h300;
      #1 chk("en_ready_t", req_ready_a, 3'b001);
      tick();
      ena = 1'b0;
      chk("en_busy_t1", busy_a, 1);
      tick();
      tick();
      chk("en_rsp_t3", rsp_valid_a, 3'b001);
      chk("en_data_t3", rsp_data_a, 32'h0BADF00D);
      tick();
      chk("en_noready_t4", req_ready_a, 0);
      chk("en_busy_t4", busy_a, 0);
      tick();
      chk("en_noready_t5", req_ready_a, 0);
      ena = 1'b1;
      #1 chk("en_regrant", req_ready_a, 3'b001);
      req_valid = '0;
      // reset during RWAIT abandons the access
      do_reset();
      tick();
      tick();
      req_valid = 3'b010;
      req_addr[32 +: 32] = 32'h44;
      #1 chk("ra_ready_t", req_ready_a, 3'b010);
      tick();
      req_valid = '0;
      tick();
      chk("ra_busy_t2", busy_a, 1);
      chk("ra_addr_t2", mem_addr_a, 32'h44);
      rst = 1'b0;
      #1;
      chk("ra_busy", busy_a, 0);
      chk("ra_addr", mem_addr_a, 0);
      chk("ra_gid", grant_id_a, 0);
      chk("ra_rsp", rsp_valid_a, 0);
      chk("ra_rspdata", rsp_data_a, 0);
      tick();
      chk("ra_rsp_hold", rsp_valid_a, 0);
      rst = 1'b1;
      tick();
      chk("ra_rsp_after", rsp_valid_a, 0);
      req_valid = 3'b111;
      #1;
      chk("ra_first_rr", req_ready_a, 3'b010);
      chk("ra_first_fp", req_ready_f, 3'b001);
      req_valid = '0;
      tick();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
